// File: rtl/uart_parity_engine.sv
// Shared UART parity unit: TX parity capture/hold and RX serial parity check.
// Optional stick (mark/space) parity is built only when UART_PAR_STICK_EN is defined.
module uart_parity_engine #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic [DATA_WIDTH-1:0] TX_DATA,
   input  logic                  TX_VALID,
   output logic                  TX_READY,
   input  logic                  TX_DONE,
   output logic                  TX_PAR_BIT,
   output logic                  TX_PAR_VALID,
   input  logic                  RX_START,
   input  logic                  RX_BIT,
   input  logic                  RX_BIT_STB,
   input  logic                  RX_PAR_STB,
   output logic                  RX_CHK_DONE,
   output logic                  RX_PAR_ERR,
   output logic                  RX_LEN_ERR
);

   localparam int CW = $clog2(DATA_WIDTH + 2);
   localparam logic [CW-1:0] CNT_LEN = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_SAT = CW'(DATA_WIDTH + 1);

`ifdef UART_PAR_STICK_EN
   localparam int TW = 2;
`else
   localparam int TW = 1;
   logic unused_typ;
   assign unused_typ = PAR_TYP[1];
`endif

   // x is the XOR of the data bits; result is the bit to send/expect
   function automatic logic par_of(input logic x, input logic [TW-1:0] t);
      logic r;
`ifdef UART_PAR_STICK_EN
      unique case (t)
         2'b00:   r = x;
         2'b01:   r = ~x;
         2'b10:   r = 1'b1;
         default: r = 1'b0;
      endcase
`else
      r = x ^ t[0];
`endif
      return r;
   endfunction

   typedef enum logic {T_IDLE, T_HOLD} tx_st_t;
   typedef enum logic {R_IDLE, R_ACC} rx_st_t;

   tx_st_t tx_st_q;
   logic   tx_rdy_q;
   logic   tx_bit_q;
   logic   tx_val_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_st_q  <= T_IDLE;
         tx_rdy_q <= 1'b1;
         tx_bit_q <= 1'b0;
         tx_val_q <= 1'b0;
      end else begin
         unique case (tx_st_q)
            T_IDLE: begin
               if (TX_VALID) begin
                  tx_st_q  <= T_HOLD;
                  tx_rdy_q <= 1'b0;
                  tx_val_q <= PAR_EN;
                  tx_bit_q <= PAR_EN & par_of(^TX_DATA, PAR_TYP[TW-1:0]);
               end
            end
            T_HOLD: begin
               if (TX_DONE) begin
                  tx_st_q  <= T_IDLE;
                  tx_rdy_q <= 1'b1;
                  tx_val_q <= 1'b0;
                  tx_bit_q <= 1'b0;
               end
            end
            default: tx_st_q <= T_IDLE;
         endcase
      end
   end

   assign TX_READY     = tx_rdy_q;
   assign TX_PAR_BIT   = tx_bit_q;
   assign TX_PAR_VALID = tx_val_q;

   rx_st_t          rx_st_q;
   logic            rx_acc_q;
   logic [CW-1:0]   rx_cnt_q;
   logic [CW-1:0]   rx_cnt_d;
   logic            rx_en_q;
   logic [TW-1:0]   rx_typ_q;
   logic            rx_done_q;
   logic            rx_perr_q;
   logic            rx_lerr_q;

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (rx_cnt_q != CNT_SAT) rx_cnt_d = rx_cnt_q + CW'(1);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_st_q   <= R_IDLE;
         rx_acc_q  <= 1'b0;
         rx_cnt_q  <= '0;
         rx_en_q   <= 1'b0;
         rx_typ_q  <= '0;
         rx_done_q <= 1'b0;
         rx_perr_q <= 1'b0;
         rx_lerr_q <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         if (RX_START) begin
            rx_st_q   <= R_ACC;
            rx_acc_q  <= 1'b0;
            rx_cnt_q  <= '0;
            rx_en_q   <= PAR_EN;
            rx_typ_q  <= PAR_TYP[TW-1:0];
            rx_perr_q <= 1'b0;
            rx_lerr_q <= 1'b0;
         end else if (rx_st_q == R_ACC) begin
            // a data strobe colliding with the parity strobe is dropped
            if (RX_PAR_STB) begin
               rx_perr_q <= rx_en_q & (RX_BIT != par_of(rx_acc_q, rx_typ_q));
               rx_lerr_q <= (rx_cnt_q != CNT_LEN) | RX_BIT_STB;
               rx_done_q <= 1'b1;
               rx_st_q   <= R_IDLE;
            end else if (RX_BIT_STB) begin
               rx_acc_q <= rx_acc_q ^ RX_BIT;
               rx_cnt_q <= rx_cnt_d;
            end
         end
      end
   end

   assign RX_CHK_DONE = rx_done_q;
   assign RX_PAR_ERR  = rx_perr_q;
   assign RX_LEN_ERR  = rx_lerr_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: directed plan cases plus randomized frames
// checked against a count-of-ones parity model.
module tb_uart_parity_engine;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          PAR_EN = 1'b0;
   logic [1:0]    PAR_TYP = 2'b00;
   logic [DW-1:0] TX_DATA = '0;
   logic          TX_VALID = 1'b0;
   logic          TX_READY;
   logic          TX_DONE = 1'b0;
   logic          TX_PAR_BIT;
   logic          TX_PAR_VALID;
   logic          RX_START = 1'b0;
   logic          RX_BIT = 1'b0;
   logic          RX_BIT_STB = 1'b0;
   logic          RX_PAR_STB = 1'b0;
   logic          RX_CHK_DONE;
   logic          RX_PAR_ERR;
   logic          RX_LEN_ERR;

   int vectors = 0;
   int errs = 0;

   uart_parity_engine #(.DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RST(RST),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .TX_DONE(TX_DONE), .TX_PAR_BIT(TX_PAR_BIT),
      .TX_PAR_VALID(TX_PAR_VALID),
      .RX_START(RX_START), .RX_BIT(RX_BIT),
      .RX_BIT_STB(RX_BIT_STB), .RX_PAR_STB(RX_PAR_STB),
      .RX_CHK_DONE(RX_CHK_DONE), .RX_PAR_ERR(RX_PAR_ERR),
      .RX_LEN_ERR(RX_LEN_ERR)
   );

   always #5 CLK = ~CLK;

   // Parity bit making the frame's total ones even (even) or odd (odd)
   function automatic logic model_par(input int ones, input logic [1:0] typ);
`ifdef UART_PAR_STICK_EN
      if (typ == 2'b10) return 1'b1;
      if (typ == 2'b11) return 1'b0;
`endif
      return ((ones + int'(typ[0])) % 2) == 1;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT, RX_CHK_DONE, RX_PAR_ERR,
           RX_LEN_ERR} !== 6'b100000) begin
         errs++;
         $display("FAIL reset: outs=%b want 100000",
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT, RX_CHK_DONE,
                   RX_PAR_ERR, RX_LEN_ERR});
      end
      RST = 1'b1;
      tick();
   endtask

   task automatic tx_frame(input logic [DW-1:0] d, input logic en,
                           input logic [1:0] typ, input int hold,
                           input string nm);
      logic eb;
      eb = en & model_par($countones(d), typ);
      TX_DATA = d; PAR_EN = en; PAR_TYP = typ; TX_VALID = 1'b1;
      tick();
      TX_VALID = 1'b0;
      for (int i = 0; i < hold; i++) begin
         vectors++;
         if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT} !== {1'b0, en, eb}) begin
            errs++;
            $display("FAIL %s hold%0d: rdy/val/bit=%b want %b", nm, i,
                     {TX_READY, TX_PAR_VALID, TX_PAR_BIT}, {1'b0, en, eb});
         end
         PAR_EN = 1'($urandom); PAR_TYP = 2'($urandom);
         TX_DATA = DW'($urandom); TX_VALID = 1'($urandom);
         tick();
      end
      TX_VALID = 1'b0; TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT} !== 3'b100) begin
         errs++;
         $display("FAIL %s done: rdy/val/bit=%b want 100", nm,
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT});
      end
   endtask

   task automatic test_tx();
      tx_frame(8'hA7, 1'b1, 2'b00, 3, "tx_even_a7");
      tx_frame(8'h0F, 1'b1, 2'b01, 4, "tx_odd_0f");
      tx_frame(8'h5A, 1'b0, 2'b01, 2, "tx_par_off");
      tx_frame(8'h00, 1'b1, 2'b10, 2, "tx_mark_00");
      tx_frame(8'h01, 1'b1, 2'b11, 2, "tx_space_01");
      TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
      tick();
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT} !== 3'b100) begin
         errs++;
         $display("FAIL tx_done_idle: rdy/val/bit=%b want 100",
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT});
      end
   endtask

   task automatic test_back_to_back();
      logic eb;
      TX_DATA = 8'h13; PAR_EN = 1'b1; PAR_TYP = 2'b00; TX_VALID = 1'b1;
      tick();
      TX_DATA = 8'h3C; PAR_TYP = 2'b01; TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT} !== 3'b100) begin
         errs++;
         $display("FAIL b2b_done: rdy/val/bit=%b want 100",
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT});
      end
      eb = model_par($countones(8'h3C), 2'b01);
      tick();
      TX_VALID = 1'b0;
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT} !== {2'b01, eb}) begin
         errs++;
         $display("FAIL b2b_capture: rdy/val/bit=%b want %b",
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT}, {2'b01, eb});
      end
      TX_DONE = 1'b1;
      tick();
      TX_DONE = 1'b0;
   endtask

   task automatic test_tx_random();
      for (int k = 0; k < 30; k++)
         tx_frame(DW'($urandom), 1'($urandom), 2'($urandom),
                  int'($urandom_range(1, 4)), "tx_rand");
   endtask

   task automatic rx_frame(input logic [9:0] d, input int n, input logic pb,
                           input logic en, input logic [1:0] typ,
                           input logic col, input int gaps, input string nm);
      int ones;
      logic eperr, elerr;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      eperr = en & (pb != model_par(ones, typ));
      elerr = (n != DW) | col;
      PAR_EN = en; PAR_TYP = typ; RX_START = 1'b1;
      tick();
      RX_START = 1'b0;
      PAR_EN = 1'($urandom); PAR_TYP = 2'($urandom);
      vectors++;
      if ({RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR} !== 3'b000) begin
         errs++;
         $display("FAIL %s start: done/perr/lerr=%b want 000", nm,
                  {RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR});
      end
      for (int i = 0; i < n; i++) begin
         RX_BIT = d[i]; RX_BIT_STB = 1'b1;
         tick();
         RX_BIT_STB = 1'b0;
         repeat ($urandom_range(0, gaps)) begin
            RX_BIT = 1'($urandom);
            tick();
         end
      end
      RX_BIT = pb; RX_PAR_STB = 1'b1; RX_BIT_STB = col;
      tick();
      RX_PAR_STB = 1'b0; RX_BIT_STB = 1'b0; RX_BIT = 1'($urandom);
      vectors++;
      if ({RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR} !== {1'b1, eperr, elerr}) begin
         errs++;
         $display("FAIL %s check: done/perr/lerr=%b want %b", nm,
                  {RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR}, {1'b1, eperr, elerr});
      end
      RX_PAR_STB = 1'b1; RX_BIT = ~RX_BIT;
      tick();
      RX_PAR_STB = 1'b0;
      vectors++;
      if ({RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR} !== {1'b0, eperr, elerr}) begin
         errs++;
         $display("FAIL %s after: done/perr/lerr=%b want %b", nm,
                  {RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR}, {1'b0, eperr, elerr});
      end
   endtask

   task automatic test_rx();
      rx_frame(10'h035, 8, 1'b0, 1'b1, 2'b00, 1'b0, 0, "rx_even_ok");
      rx_frame(10'h035, 8, 1'b1, 1'b1, 2'b00, 1'b0, 0, "rx_even_bad");
      rx_frame(10'h035, 7, 1'b0, 1'b1, 2'b00, 1'b0, 1, "rx_short");
      rx_frame(10'h3FF, 10, 1'b0, 1'b1, 2'b01, 1'b0, 0, "rx_long_sat");
      rx_frame(10'h0A5, 8, 1'b1, 1'b1, 2'b00, 1'b1, 0, "rx_collide");
      rx_frame(10'h000, 8, 1'b0, 1'b1, 2'b10, 1'b0, 0, "rx_mark_0");
      rx_frame(10'h035, 8, 1'b1, 1'b0, 2'b00, 1'b0, 0, "rx_par_off");
   endtask

   task automatic test_rx_abort();
      PAR_EN = 1'b1; PAR_TYP = 2'b01; RX_START = 1'b1;
      tick();
      RX_START = 1'b0;
      for (int i = 0; i < 4; i++) begin
         RX_BIT = 1'b1; RX_BIT_STB = 1'b1;
         tick();
      end
      RX_BIT_STB = 1'b0;
      vectors++;
      if (RX_CHK_DONE !== 1'b0) begin
         errs++;
         $display("FAIL rx_abort_mid: done=%b want 0", RX_CHK_DONE);
      end
      rx_frame(10'h035, 8, 1'b0, 1'b1, 2'b00, 1'b0, 1, "rx_after_abort");
   endtask

   task automatic test_rx_random();
      int n;
      for (int k = 0; k < 40; k++) begin
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 10)) : DW;
         rx_frame(10'($urandom), n, 1'($urandom), 1'($urandom),
                  2'($urandom), ($urandom_range(0, 7) == 0), 2, "rx_rand");
      end
   endtask

   task automatic test_reset_midframe();
      rx_frame(10'h035, 6, 1'b1, 1'b1, 2'b00, 1'b0, 0, "rx_pre_rst");
      TX_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 2'b00; TX_VALID = 1'b1;
      tick();
      TX_VALID = 1'b0;
      #1 RST = 1'b0;
      #1;
      vectors++;
      if ({TX_READY, TX_PAR_VALID, TX_PAR_BIT, RX_CHK_DONE, RX_PAR_ERR,
           RX_LEN_ERR} !== 6'b100000) begin
         errs++;
         $display("FAIL rst_hold: outs=%b want 100000",
                  {TX_READY, TX_PAR_VALID, TX_PAR_BIT, RX_CHK_DONE,
                   RX_PAR_ERR, RX_LEN_ERR});
      end
      #1 RST = 1'b1;
      tick();
      PAR_EN = 1'b1; RX_START = 1'b1;
      tick();
      RX_START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         RX_BIT = 1'b1; RX_BIT_STB = 1'b1;
         tick();
      end
      RX_BIT_STB = 1'b0;
      #1 RST = 1'b0;
      #1 RST = 1'b1;
      tick();
      RX_PAR_STB = 1'b1; RX_BIT = 1'b0;
      tick();
      RX_PAR_STB = 1'b0;
      vectors++;
      if ({RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR} !== 3'b000) begin
         errs++;
         $display("FAIL rst_racc: done/perr/lerr=%b want 000",
                  {RX_CHK_DONE, RX_PAR_ERR, RX_LEN_ERR});
      end
   endtask

   initial begin
      test_reset();
      test_tx();
      test_back_to_back();
      test_tx_random();
      test_rx();
      test_rx_abort();
      test_rx_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity unit shared by the UART TX and RX paths. On TX it captures a parallel word through a valid/ready handshake and holds the computed parity bit stable until the serializer reports frame completion. On RX it accumulates parity serially from sampled data-bit strobes and checks the received parity bit, reporting parity and length errors. It sits between the frame FSMs and the shift registers on both sides.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- PAR_EN  in  1  parity enable; sampled at TX capture and at RX_START.
- PAR_TYP  in  2  parity type: 00 even, 01 odd, 10 mark, 11 space.
- TX_DATA  in  DATA_WIDTH  word to protect.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  block can accept a TX word.
- TX_DONE  in  1  one-cycle pulse from the serializer at end of frame.
- TX_PAR_BIT  out  1  held parity bit.
- TX_PAR_VALID  out  1  TX_PAR_BIT is meaningful for the current frame.
- RX_START  in  1  start-of-frame pulse.
- RX_BIT  in  1  sampled serial bit.
- RX_BIT_STB  in  1  RX_BIT is a data bit.
- RX_PAR_STB  in  1  RX_BIT is the parity bit.
- RX_CHK_DONE  out  1  one-cycle pulse: check complete.
- RX_PAR_ERR  out  1  parity mismatch of the last checked frame.
- RX_LEN_ERR  out  1  data-bit count of the last frame was not DATA_WIDTH.

## Operation
- Parity function: even = ^data, so the total count of ones is even. Odd = ~^data. Mark = 1. Space = 0.
- TX FSM states: T_IDLE, T_HOLD.
  - T_IDLE: TX_READY=1. When TX_VALID&TX_READY, register parity of TX_DATA using the current PAR_EN and PAR_TYP, then go to T_HOLD.
  - T_HOLD: TX_READY=0; TX_PAR_BIT and TX_PAR_VALID are frozen, and changes to PAR_EN or PAR_TYP are ignored. On TX_DONE, go to T_IDLE and clear TX_PAR_VALID and TX_PAR_BIT.
  - If PAR_EN=0 at capture: TX_PAR_BIT=0 and TX_PAR_VALID=0. The FSM still enters T_HOLD so the handshake flow is unchanged.
  - TX_DONE in T_IDLE is ignored.
- RX FSM states: R_IDLE, R_ACC.
  - RX_START in any state: acc=0, cnt=0, capture PAR_EN and PAR_TYP, clear RX_PAR_ERR and RX_LEN_ERR, go to R_ACC. RX_START in R_ACC aborts the frame silently, with no RX_CHK_DONE.
  - R_ACC, RX_BIT_STB: acc ^= RX_BIT. cnt increments and saturates at DATA_WIDTH+1. cnt is $clog2(DATA_WIDTH+2) bits wide.
  - R_ACC, RX_PAR_STB: the expected bit is derived from acc and the captured type. Then:
    - RX_PAR_ERR = captured PAR_EN & (RX_BIT != expected).
    - RX_LEN_ERR = (cnt != DATA_WIDTH).
    - Pulse RX_CHK_DONE and return to R_IDLE.
  - RX_BIT_STB and RX_PAR_STB in the same cycle: the parity strobe is processed, the data strobe is dropped, and RX_LEN_ERR is forced to 1.
  - Strobes in R_IDLE are ignored.
  - RX_PAR_ERR and RX_LEN_ERR hold until the next RX_START or reset.
- TX and RX paths are fully independent and may be active in the same cycle.

## Timing
- Reset values: TX_READY=1 (T_IDLE); TX_PAR_BIT, TX_PAR_VALID, RX_CHK_DONE, RX_PAR_ERR and RX_LEN_ERR are 0; FSMs are idle; acc=0, cnt=0.
- Reset mid-frame: state returns to idle immediately; no done pulse is produced.
- TX latency: handshake in cycle N gives TX_PAR_VALID and TX_PAR_BIT valid from N+1. TX_READY drops in N+1 and is high again the cycle after TX_DONE.
- Back-to-back TX: TX_DONE in cycle M allows a new capture in M+1.
- RX latency: RX_PAR_STB in cycle N gives RX_CHK_DONE high in N+1 only, with both error flags valid from N+1.
- RX_START and the check are registered; a new RX_START in N+1 clears the flags in N+2.

## Configuration
- UART_PAR_STICK_EN defined: mark and space types (PAR_TYP 10 and 11) behave as described above.
- UART_PAR_STICK_EN undefined: PAR_TYP[1] is ignored, so 10 behaves as even and 11 as odd. Stick-parity logic is not synthesised.

## Test plan
- Reset, then TX even with TX_DATA=8'hA7: TX_PAR_BIT=1 and TX_PAR_VALID=1 one cycle after the handshake. TX_READY stays 0 until TX_DONE, then returns to 1.
- TX odd with TX_DATA=8'h0F, then change PAR_TYP to 00 while in T_HOLD: TX_PAR_BIT stays 1 until TX_DONE.
- RX even, 8 data bits of 8'h35, parity bit 0: RX_CHK_DONE pulses for one cycle with RX_PAR_ERR=0 and RX_LEN_ERR=0. Repeat with parity bit 1: RX_PAR_ERR=1.
- RX with 7 data strobes then RX_PAR_STB: RX_LEN_ERR=1. RX_START mid-frame followed by a clean 8-bit frame: single RX_CHK_DONE pulse, no errors.
- With UART_PAR_STICK_EN: PAR_TYP=10, TX_DATA=8'h00 gives TX_PAR_BIT=1; RX mark frame with parity 0 gives RX_PAR_ERR=1. Without the macro: the same TX stimulus gives TX_PAR_BIT=0 (even).
- Assert RST low while in T_HOLD and R_ACC: all outputs return to reset values asynchronously. PAR_EN=0 RX frame with a bad parity bit: RX_PAR_ERR=0.
